irq_sched: RTL and testbench

Sequential priority interrupt scheduler that shares a single interrupt line between `N_CH` requesters. It uses the same fixed-priority rule as the team's 27-channel combinational interrupt-priority benchmark: the lowest channel index wins. The block adds what that combinational encoder lacks:

- edge capture of requests into pending bits;
- a mask register;
- a request/acknowledge/end-of-interrupt handshake with one interrupt in service at a time.

It sits between the benchmark-style request sources and a host or CPU model in the simulation testbenches.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_sched.sv | 97 +++++++++
 tb/tb_irq_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt scheduler family.
package irq_pkg;

   localparam int IRQ_N_CH  = 9;
   localparam int IRQ_VEC_W = 4;

   typedef enum logic [1:0] {
      IRQ_IDLE  = 2'd0,
      IRQ_ISSUE = 2'd1,
      IRQ_SVC   = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N_CH  = IRQ_N_CH,
   parameter int VEC_W = IRQ_VEC_W
) (
   input  logic [N_CH-1:0]  din,
   output logic             valid,
   output logic [VEC_W-1:0] idx
);

   always_comb begin
      valid = |din;
      idx   = '0;
      // Scan downward so the lowest set bit is the last (winning) assignment.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (din[i]) idx = VEC_W'(i);
      end
   end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge-captured pending bits, mask, and one-at-a-time
// issue/ack/eoi handshake to a single host interrupt line.
//
// state     | meaning
// IRQ_IDLE  | nothing issued; waiting for an unmasked pending channel
// IRQ_ISSUE | irq asserted with vec, waiting for ack
// IRQ_SVC   | host servicing vec, waiting for eoi
module irq_sched
   import irq_pkg::*;
#(
   parameter int N_CH  = IRQ_N_CH,
   parameter int VEC_W = IRQ_VEC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  req,
   input  logic             mask_wr,
   input  logic [N_CH-1:0]  mask_din,
   input  logic             ack,
   input  logic             eoi,
   output logic             irq,
   output logic [VEC_W-1:0] vec,
   output logic             busy,
   output logic [N_CH-1:0]  pend
);

   irq_state_e       state, state_nx;
   logic [N_CH-1:0]  req_q;
   logic [N_CH-1:0]  mask;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  cand;
   logic [N_CH-1:0]  clr;
   logic [N_CH-1:0]  pend_nx;
   logic [VEC_W-1:0] vec_nx;
   logic             win_valid;
   logic [VEC_W-1:0] win_idx;

   irq_prio_enc #(
      .N_CH  (N_CH),
      .VEC_W (VEC_W)
   ) u_prio_enc (
      .din   (cand),
      .valid (win_valid),
      .idx   (win_idx)
   );

   always_comb begin
      rise     = req & ~req_q;
      cand     = pend & ~mask;
      clr      = '0;
      state_nx = state;
      vec_nx   = vec;
      case (state)
         IRQ_IDLE: begin
            if (win_valid) begin
               state_nx = IRQ_ISSUE;
               vec_nx   = win_idx;
            end
         end
         IRQ_ISSUE: begin
            if (ack) begin
               state_nx = IRQ_SVC;
               for (int i = 0; i < N_CH; i++) begin
                  if (VEC_W'(i) == vec) clr[i] = 1'b1;
               end
            end
         end
         IRQ_SVC: begin
            if (eoi) state_nx = IRQ_IDLE;
         end
         default: state_nx = IRQ_IDLE;
      endcase
      // A fresh edge on the acknowledged channel re-arms it rather than being lost.
      pend_nx = (pend & ~clr) | rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IRQ_IDLE;
         req_q <= '0;
         pend  <= '0;
         mask  <= '0;
         vec   <= '0;
         irq   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         req_q <= req;
         pend  <= pend_nx;
         if (mask_wr) mask <= mask_din;
         vec   <= vec_nx;
         irq   <= (state_nx == IRQ_ISSUE);
         busy  <= (state_nx == IRQ_SVC);
      end
   end

endmodule

// File: tb/tb_irq_sched.sv
// Directed and randomized checks of irq_sched against a behavioural model.
module tb_irq_sched;

   localparam int N = 9;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         mask_wr;
   logic [N-1:0] mask_din;
   logic         ack;
   logic         eoi;
   logic         irq;
   logic [W-1:0] vec;
   logic         busy;
   logic [N-1:0] pend;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: pending set, mask, and two flags for issued / in service.
   logic [N-1:0] m_req_q;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_mask;
   bit           m_issued;
   bit           m_svc;
   int           m_vec;

   irq_sched #(.N_CH(N), .VEC_W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .mask_wr  (mask_wr),
      .mask_din (mask_din),
      .ack      (ack),
      .eoi      (eoi),
      .irq      (irq),
      .vec      (vec),
      .busy     (busy),
      .pend     (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_req_q  = '0;
      m_pend   = '0;
      m_mask   = '0;
      m_issued = 1'b0;
      m_svc    = 1'b0;
      m_vec    = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] r, input logic mw, input logic [N-1:0] md,
                             input logic a, input logic e);
      logic [N-1:0] rise;
      logic [N-1:0] base;
      logic [N-1:0] cand;
      bit           found;
      rise  = r & ~m_req_q;
      base  = m_pend;
      cand  = m_pend & ~m_mask;
      found = 1'b0;
      if (m_issued) begin
         if (a) begin
            base[m_vec] = 1'b0;
            m_issued    = 1'b0;
            m_svc       = 1'b1;
         end
      end else if (m_svc) begin
         if (e) m_svc = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!found && cand[i]) begin
               found    = 1'b1;
               m_vec    = i;
               m_issued = 1'b1;
            end
         end
      end
      m_pend  = base | rise;
      if (mw) m_mask = md;
      m_req_q = r;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".irq"},  32'(irq),  32'(m_issued));
      chk({tag, ".busy"}, 32'(busy), 32'(m_svc));
      chk({tag, ".vec"},  32'(vec),  32'(m_vec));
      chk({tag, ".pend"}, 32'(pend), 32'(m_pend));
   endtask

   task automatic step(input logic [N-1:0] r, input logic mw, input logic [N-1:0] md,
                       input logic a, input logic e, input string tag);
      req      = r;
      mask_wr  = mw;
      mask_din = md;
      ack      = a;
      eoi      = e;
      @(posedge clk);
      model_edge(r, mw, md, a, e);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [N-1:0] r;
      logic         mw;
      logic [N-1:0] md;
      rst = 1'b1; req = '0; mask_wr = 1'b0; mask_din = '0; ack = 1'b0; eoi = 1'b0;
      model_reset();
      #3;
      chk("rst.irq",  32'(irq),  32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.vec",  32'(vec),  32'd0);
      chk("rst.pend", 32'(pend), 32'd0);
      #9 rst = 1'b0;

      // single request on channel 5
      step(9'h020, 0, '0, 0, 0, "t1.e0");
      step(9'h020, 0, '0, 0, 0, "t1.e1");
      chk("t1.irq_up", 32'(irq), 32'd1);
      chk("t1.vec5",   32'(vec), 32'd5);
      step(9'h020, 0, '0, 1, 0, "t1.ack");
      chk("t1.busy", 32'(busy), 32'd1);
      chk("t1.pend5_clr", 32'(pend[5]), 32'd0);
      step(9'h020, 0, '0, 0, 1, "t1.eoi");
      step(9'h000, 0, '0, 0, 0, "t1.idle");

      // priority between 7 and 2
      step(9'h084, 0, '0, 0, 0, "t2.e0");
      step(9'h084, 0, '0, 0, 0, "t2.e1");
      chk("t2.vec2", 32'(vec), 32'd2);
      step(9'h084, 0, '0, 1, 0, "t2.ack");
      step(9'h084, 0, '0, 0, 1, "t2.eoi");
      step(9'h000, 0, '0, 0, 0, "t2.reissue");
      chk("t2.vec7", 32'(vec), 32'd7);
      chk("t2.irq7", 32'(irq), 32'd1);
      step(9'h000, 0, '0, 1, 0, "t2.ack7");
      step(9'h000, 0, '0, 0, 1, "t2.eoi7");

      // masked channel latches but does not issue
      step(9'h000, 1, 9'h004, 0, 0, "t3.mask");
      step(9'h004, 0, '0, 0, 0, "t3.e0");
      step(9'h004, 0, '0, 0, 0, "t3.e1");
      step(9'h004, 0, '0, 0, 0, "t3.e2");
      chk("t3.no_irq", 32'(irq),  32'd0);
      chk("t3.pend",   32'(pend), 32'h004);
      step(9'h004, 1, 9'h000, 0, 0, "t3.unmask");
      step(9'h004, 0, '0, 0, 0, "t3.issue");
      chk("t3.irq", 32'(irq), 32'd1);
      chk("t3.vec", 32'(vec), 32'd2);
      step(9'h000, 0, '0, 1, 0, "t3.ack");
      step(9'h000, 0, '0, 0, 1, "t3.eoi");

      // no preemption while servicing channel 4
      step(9'h010, 0, '0, 0, 0, "t4.e0");
      step(9'h010, 0, '0, 0, 0, "t4.e1");
      step(9'h010, 1, 9'h010, 1, 0, "t4.ack_mask4");
      step(9'h011, 0, '0, 0, 0, "t4.req0");
      chk("t4.irq_low", 32'(irq),     32'd0);
      chk("t4.pend0",   32'(pend[0]), 32'd1);
      step(9'h011, 1, 9'h000, 0, 1, "t4.eoi");
      step(9'h000, 0, '0, 0, 0, "t4.issue0");
      chk("t4.vec0", 32'(vec), 32'd0);
      step(9'h000, 0, '0, 1, 1, "t4.ack_eoi");
      step(9'h000, 0, '0, 0, 1, "t4.eoi0");

      // set wins over ack clear on channel 3
      step(9'h008, 0, '0, 0, 0, "t5.e0");
      step(9'h000, 0, '0, 0, 0, "t5.e1");
      step(9'h008, 0, '0, 1, 0, "t5.collide");
      chk("t5.pend3", 32'(pend[3]), 32'd1);
      step(9'h008, 0, '0, 0, 1, "t5.eoi");
      step(9'h008, 0, '0, 0, 0, "t5.reissue");
      chk("t5.vec3", 32'(vec), 32'd3);
      step(9'h000, 0, '0, 1, 0, "t5.ack");
      step(9'h000, 0, '0, 0, 1, "t5.eoi2");

      // async reset during ISSUE of channel 6, request held through reset
      step(9'h040, 1, 9'h100, 0, 0, "t6.e0");
      step(9'h040, 0, '0, 0, 0, "t6.e1");
      chk("t6.issued", 32'(irq), 32'd1);
      rst = 1'b1;
      #2;
      chk("t6.rst_irq",  32'(irq),  32'd0);
      chk("t6.rst_busy", 32'(busy), 32'd0);
      chk("t6.rst_vec",  32'(vec),  32'd0);
      chk("t6.rst_pend", 32'(pend), 32'd0);
      model_reset();
      #2 rst = 1'b0;
      step(9'h040, 0, '0, 0, 0, "t6.recapture");
      chk("t6.pend6", 32'(pend[6]), 32'd1);
      step(9'h040, 0, '0, 0, 0, "t6.issue");
      step(9'h040, 0, '0, 1, 0, "t6.ack");
      step(9'h000, 0, '0, 0, 1, "t6.eoi");

      // randomized traffic
      r = '0;
      for (int k = 0; k < 800; k++) begin
         r  = r ^ (N'($urandom) & N'($urandom) & N'($urandom));
         mw = ($urandom_range(0, 15) == 0);
         md = N'($urandom) & N'($urandom);
         step(r, mw, md, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
